// File: rtl/csr_master_bfm_if.sv
// rtl/csr_master_bfm_if.sv - command, response and CSR bus signals for csr_master_bfm
interface csr_master_bfm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic [1:0]        cmd_priv;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic              busy;

  logic              csr_req_valid;
  logic              csr_req_write;
  logic [ADDR_W-1:0] csr_req_addr;
  logic [DATA_W-1:0] csr_req_wdata;
  logic [STRB_W-1:0] csr_req_wstrb;
  logic [1:0]        csr_req_priv;
  logic              csr_req_ready;

  logic              csr_rsp_valid;
  logic [DATA_W-1:0] csr_rsp_rdata;
  logic              csr_rsp_fault;
  logic              csr_rsp_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_priv,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_fault,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
    output csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata,
    output csr_req_wstrb, csr_req_priv, csr_rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_priv,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_fault,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
    input  csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata,
    input  csr_req_wstrb, csr_req_priv, csr_rsp_ready
  );
endinterface

// File: rtl/csr_master_bfm.sv
// rtl/csr_master_bfm.sv - single-outstanding CSR bus master with response timeout
module csr_master_bfm #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               rst,
  csr_master_bfm_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        priv_q, priv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      priv_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      priv_q  <= priv_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    priv_d  = priv_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          priv_d  = bus.cmd_priv;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        // Timeout beats a late grant so the counter can never step past the limit.
        if (cnt_inc == CNT_LIMIT) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else if (bus.csr_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_inc;
        // A response landing on the timeout cycle is still a real response.
        if (bus.csr_rsp_valid) begin
          rdata_d = write_q ? '0 : bus.csr_rsp_rdata;
          fault_d = bus.csr_rsp_fault;
          state_d = ST_DONE;
        end else if (cnt_inc == CNT_LIMIT) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs decode the state register or latched fields only.
  assign bus.cmd_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.rsp_valid     = (state_q == ST_DONE);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_fault     = fault_q;
  assign bus.csr_req_valid = (state_q == ST_REQ);
  assign bus.csr_req_write = write_q;
  assign bus.csr_req_addr  = addr_q;
  assign bus.csr_req_wdata = wdata_q;
  assign bus.csr_req_wstrb = wstrb_q;
  assign bus.csr_req_priv  = priv_q;
  assign bus.csr_rsp_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
endmodule

// File: tb/tb_csr_master_bfm.sv
// tb/tb_csr_master_bfm.sv - scoreboard bench for csr_master_bfm
module tb_csr_master_bfm;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_master_bfm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  csr_master_bfm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          fault;
    int            exp_cyc;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  rsp_count = 0;
  int  cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        expect_eq("unexpected_rsp", 128'(sb_q.size()), 128'd1);
      end else begin
        e = sb_q.pop_front();
        expect_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
        expect_eq("rsp_fault", bus.rsp_fault, e.fault);
        expect_eq("rsp_cycle", 128'(cyc), 128'(e.exp_cyc));
      end
      rsp_count++;
    end
  end

  // Latency counts the accept cycle: 3 with an immediate slave, TO+1 on timeout.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] wstrb, input logic [1:0] priv, input int req_wait,
                        input int rsp_wait, input logic never_ready, input logic [DW-1:0] s_rdata,
                        input logic s_fault);
    sb_t  e;
    int   n0;
    int   acc;
    int   lat;
    logic to;
    to  = never_ready || (req_wait + rsp_wait + 2 > TO);
    lat = to ? TO + 1 : 3 + req_wait + rsp_wait;
    expect_eq("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    bus.cmd_priv  = priv;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '1;
    bus.cmd_wdata = '1;
    acc = cyc;
    e.rdata   = to ? '0 : (wr ? '0 : s_rdata);
    e.fault   = to ? 1'b1 : s_fault;
    e.exp_cyc = acc + lat - 1;
    sb_q.push_back(e);
    n0 = rsp_count;
    expect_eq("req_valid", bus.csr_req_valid, 1'b1);
    expect_eq("busy_req", bus.busy, 1'b1);
    expect_eq("req_fields",
              {bus.csr_req_write, bus.csr_req_addr, bus.csr_req_wdata, bus.csr_req_wstrb, bus.csr_req_priv},
              {wr, addr, wdata, wstrb, priv});
    if (!never_ready) begin
      for (int i = 0; i < req_wait; i++) begin
        @(posedge clk); #1;
      end
      bus.csr_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.csr_req_ready = 1'b0;
      expect_eq("req_released", bus.csr_req_valid, 1'b0);
      for (int i = 0; i < rsp_wait; i++) begin
        @(posedge clk); #1;
      end
      bus.csr_rsp_valid = 1'b1;
      bus.csr_rsp_rdata = s_rdata;
      bus.csr_rsp_fault = s_fault;
      @(posedge clk); #1;
      bus.csr_rsp_valid = 1'b0;
      bus.csr_rsp_rdata = '0;
      bus.csr_rsp_fault = 1'b0;
    end
    for (int i = 0; i < TO + 8 && rsp_count == n0; i++) begin
      @(posedge clk); #1;
    end
    expect_eq("rsp_seen", 128'(rsp_count), 128'(n0 + 1));
    expect_eq("busy_after", bus.busy, 1'b0);
    expect_eq("cmd_ready_after", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    expect_eq("single_pulse", 128'(rsp_count), 128'(n0 + 1));
    expect_eq("hold_rdata", bus.rsp_rdata, e.rdata);
    expect_eq("hold_fault", bus.rsp_fault, e.fault);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.cmd_wstrb     = '0;
    bus.cmd_priv      = '0;
    bus.csr_req_ready = 1'b0;
    bus.csr_rsp_valid = 1'b0;
    bus.csr_rsp_rdata = '0;
    bus.csr_rsp_fault = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_req_valid", bus.csr_req_valid, 1'b0);
    expect_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    expect_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    expect_eq("rst_rsp_fault", bus.rsp_fault, 1'b0);
    expect_eq("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // write, slave immediate; slave data must be ignored for a write
    do_cmd(1'b1, 32'h10, 32'h3FF0_0000, 4'hF, 2'd0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // read with 4-cycle response delay
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, 2'd1, 0, 4, 1'b0, 32'h4008_0000, 1'b0);
    // slave-reported privilege fault
    do_cmd(1'b0, 32'h18, 32'h0, 4'h0, 2'd0, 1, 2, 1'b0, 32'h1234_5678, 1'b1);
    // request never granted
    do_cmd(1'b0, 32'h1C, 32'h0, 4'h0, 2'd3, 0, 0, 1'b1, 32'h0, 1'b0);
    do_cmd(1'b1, 32'h20, 32'hA5A5_0F0F, 4'h5, 2'd2, 2, 1, 1'b0, 32'h0, 1'b0);
    // response on exactly the timeout cycle wins
    do_cmd(1'b0, 32'h24, 32'h0, 4'h0, 2'd1, 0, TO - 2, 1'b0, 32'hCAFE_0001, 1'b0);
    // response one cycle too late: timeout, late response ignored
    do_cmd(1'b0, 32'h28, 32'h0, 4'h0, 2'd1, 0, TO - 1, 1'b0, 32'hCAFE_0002, 1'b0);

    // status polling: bit0 set for five reads, then clear
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] st;
      st = (i < 5) ? 32'h0000_0081 : 32'h0000_0080;
      do_cmd(1'b0, 32'h30, 32'h0, 4'h0, 2'd0, 0, 1, 1'b0, st, 1'b0);
      expect_eq("poll_bit0", bus.rsp_rdata[0], (i < 5) ? 1'b1 : 1'b0);
    end

    // reset while waiting for the response
    n0 = rsp_count;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid     = 1'b0;
    bus.csr_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.csr_req_ready = 1'b0;
    expect_eq("mid_busy_resp", bus.busy, 1'b1);
    expect_eq("mid_rsp_ready", bus.csr_rsp_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_eq("mid_rst_busy", bus.busy, 1'b0);
    expect_eq("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
    expect_eq("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    bus.csr_rsp_valid = 1'b1;
    bus.csr_rsp_rdata = 32'h5555_AAAA;
    bus.csr_rsp_fault = 1'b1;
    @(posedge clk); #1;
    bus.csr_rsp_valid = 1'b0;
    bus.csr_rsp_rdata = '0;
    bus.csr_rsp_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("late_rsp_no_output", 128'(rsp_count), 128'(n0));
    expect_eq("late_rsp_busy", bus.busy, 1'b0);
    expect_eq("late_rsp_fault", bus.rsp_fault, 1'b0);
    do_cmd(1'b0, 32'h44, 32'h0, 4'h0, 2'd0, 0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);

    expect_eq("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
